// File: rtl/udm_host_if.sv
// Host-side request/response bundle for udm_host: one request in, one completion out.
// The master drives a transaction and the slave (udm_host) acknowledges and completes it.
interface udm_host_if;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_bi;
  logic [31:0] wdata_bi;
  logic        ack_o;
  logic        resp_o;
  logic        err_o;
  logic [31:0] rdata_bo;

  modport master (
    output req_i,
    output we_i,
    output addr_bi,
    output wdata_bi,
    input  ack_o,
    input  resp_o,
    input  err_o,
    input  rdata_bo
  );

  modport slave (
    input  req_i,
    input  we_i,
    input  addr_bi,
    input  wdata_bi,
    output ack_o,
    output resp_o,
    output err_o,
    output rdata_bo
  );
endinterface

// File: rtl/udm_host.sv
// UDM bus host: turns single-word read/write requests into escaped UART frames and decodes replies.
// Optional response timeout in RX_DATA is enabled by defining UDM_HOST_TIMEOUT_EN.
module udm_host #(
  parameter int unsigned RESP_TIMEOUT = 1048576
) (
  input  logic       clk_i,
  input  logic       reset_i,
  udm_host_if.slave  bus,
  output logic [7:0] tx_dout_bo,
  output logic       tx_start_o,
  input  logic       tx_done_tick_i,
  input  logic       rx_done_tick_i,
  input  logic [7:0] rx_din_bi,
  output logic       irq_o
);

  localparam logic [7:0] SyncByte = 8'h55;
  localparam logic [7:0] EscByte  = 8'h5A;

  typedef enum logic [2:0] {
    StIdle,
    StSend,
    StSendEsc,
    StWaitTx,
    StRxData,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  idx_q, idx_d;
  logic        tx_esc_q, tx_esc_d;
  logic        rx_esc_q, rx_esc_d;
  logic [1:0]  rx_cnt_q, rx_cnt_d;
  logic [23:0] rx_data_q, rx_data_d;
  logic [7:0]  tx_dout_q, tx_dout_d;
  logic        tx_start_q, tx_start_d;
  logic        ack_q, ack_d;
  logic        resp_q, resp_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        irq_q, irq_d;

  logic [7:0]  frame_byte;
  logic        needs_esc;
  logic        last_byte;
  logic        rx_is_data;
  logic        rx_is_term;

`ifdef UDM_HOST_TIMEOUT_EN
  logic [31:0] to_cnt_q, to_cnt_d;
`else
  logic        unused_resp_timeout;
  assign unused_resp_timeout = ^RESP_TIMEOUT;
`endif

  // Frame layout by index: sync, cmd, addr[0..3], length[0..3], wdata[0..3].
  always_comb begin
    frame_byte = 8'h00;
    case (idx_q)
      4'd0:    frame_byte = SyncByte;
      4'd1:    frame_byte = we_q ? 8'h81 : 8'h82;
      4'd2:    frame_byte = addr_q[7:0];
      4'd3:    frame_byte = addr_q[15:8];
      4'd4:    frame_byte = addr_q[23:16];
      4'd5:    frame_byte = addr_q[31:24];
      4'd6:    frame_byte = 8'h04;
      4'd10:   frame_byte = wdata_q[7:0];
      4'd11:   frame_byte = wdata_q[15:8];
      4'd12:   frame_byte = wdata_q[23:16];
      4'd13:   frame_byte = wdata_q[31:24];
      default: frame_byte = 8'h00;
    endcase
  end

  assign needs_esc = (idx_q != 4'd0) && ((frame_byte == SyncByte) || (frame_byte == EscByte));
  assign last_byte = (idx_q == (we_q ? 4'd13 : 4'd9));

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    idx_d      = idx_q;
    tx_esc_d   = tx_esc_q;
    rx_esc_d   = rx_esc_q;
    rx_cnt_d   = rx_cnt_q;
    rx_data_d  = rx_data_q;
    tx_dout_d  = tx_dout_q;
    tx_start_d = 1'b0;
    ack_d      = 1'b0;
    resp_d     = 1'b0;
    err_d      = err_q;
    rdata_d    = rdata_q;
    irq_d      = 1'b0;
    rx_is_data = 1'b0;
    rx_is_term = 1'b0;
`ifdef UDM_HOST_TIMEOUT_EN
    to_cnt_d   = '0;
`endif

    unique case (state_q)
      StIdle: begin
        if (bus.req_i) begin
          we_d     = bus.we_i;
          addr_d   = bus.addr_bi;
          wdata_d  = bus.wdata_bi;
          idx_d    = 4'd0;
          tx_esc_d = 1'b0;
          ack_d    = 1'b0 | 1'b1;
          err_d    = 1'b0;
          rdata_d  = '0;
          state_d  = StSend;
        end
      end
      StSend: begin
        tx_start_d = 1'b1;
        if (needs_esc) begin
          tx_dout_d = EscByte;
          tx_esc_d  = 1'b1;
        end else begin
          tx_dout_d = frame_byte;
        end
        state_d = StWaitTx;
      end
      StSendEsc: begin
        tx_start_d = 1'b1;
        tx_dout_d  = frame_byte;
        tx_esc_d   = 1'b0;
        state_d    = StWaitTx;
      end
      StWaitTx: begin
        if (tx_done_tick_i) begin
          if (tx_esc_q) begin
            state_d = StSendEsc;
          end else if (last_byte) begin
            if (we_q) begin
              state_d = StDone;
            end else begin
              rx_cnt_d = 2'd0;
              state_d  = StRxData;
            end
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = StSend;
          end
        end
      end
      StRxData: begin
        // Received bytes are decoded below so irq_o also works outside this state.
      end
      StDone: begin
        resp_d  = 1'b1;
        err_d   = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Receive-side escape tracking runs in every state; only RX_DATA consumes data.
    if (rx_done_tick_i) begin
      if (rx_esc_q) begin
        rx_esc_d   = 1'b0;
        rx_is_data = 1'b1;
      end else if (rx_din_bi == EscByte) begin
        rx_esc_d = 1'b1;
      end else if (rx_din_bi == 8'h00) begin
        irq_d = 1'b1;
      end else if ((rx_din_bi == 8'h01) || (rx_din_bi == 8'h02)) begin
        rx_is_term = 1'b1;
      end else begin
        rx_is_data = 1'b1;
      end
    end

    if (state_q == StRxData) begin
      if (rx_is_term) begin
        resp_d  = 1'b1;
        err_d   = 1'b1;
        rdata_d = '0;
        state_d = StIdle;
      end else if (rx_is_data) begin
        if (rx_cnt_q == 2'd3) begin
          resp_d  = 1'b1;
          err_d   = 1'b0;
          rdata_d = {rx_din_bi, rx_data_q};
          state_d = StIdle;
        end else begin
          case (rx_cnt_q)
            2'd0:    rx_data_d[7:0]   = rx_din_bi;
            2'd1:    rx_data_d[15:8]  = rx_din_bi;
            default: rx_data_d[23:16] = rx_din_bi;
          endcase
          rx_cnt_d = rx_cnt_q + 2'd1;
        end
      end
    end

`ifdef UDM_HOST_TIMEOUT_EN
    if (state_q == StRxData) begin
      to_cnt_d = to_cnt_q + 32'd1;
      if ((state_d == StRxData) && (to_cnt_q == 32'(RESP_TIMEOUT - 1))) begin
        resp_d  = 1'b1;
        err_d   = 1'b1;
        rdata_d = '0;
        state_d = StIdle;
      end
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      idx_q      <= '0;
      tx_esc_q   <= 1'b0;
      rx_esc_q   <= 1'b0;
      rx_cnt_q   <= '0;
      rx_data_q  <= '0;
      tx_dout_q  <= 8'h00;
      tx_start_q <= 1'b0;
      ack_q      <= 1'b0;
      resp_q     <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      idx_q      <= idx_d;
      tx_esc_q   <= tx_esc_d;
      rx_esc_q   <= rx_esc_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_data_q  <= rx_data_d;
      tx_dout_q  <= tx_dout_d;
      tx_start_q <= tx_start_d;
      ack_q      <= ack_d;
      resp_q     <= resp_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      irq_q      <= irq_d;
    end
  end

`ifdef UDM_HOST_TIMEOUT_EN
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`endif

  assign tx_dout_bo   = tx_dout_q;
  assign tx_start_o   = tx_start_q;
  assign irq_o        = irq_q;
  assign bus.ack_o    = ack_q;
  assign bus.resp_o   = resp_q;
  assign bus.err_o    = err_q;
  assign bus.rdata_bo = rdata_q;

endmodule
